calc_key_sequencer: RTL and testbench
=====================================

# calc_key_sequencer

Sequences key codes from two input sources, the front-panel keypad (requester 0) and the serial console (requester 1), into the calculator datapath. It arbitrates the sources round-robin and buffers accepted codes in a small FIFO. It issues one code per calculator enable pulse and never issues while the calculator reports OCUPADA. In ERRO it forwards only backspace and discards and counts everything else.

## Interface
- FIFO_DEPTH, 4, key FIFO entries; power of two, ≥2
- CNT_W, 8, width of saturating drop counter
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- req0_valid  in  1  keypad has a key code
- req0_key  in  4  keypad key code
- req0_ready  out  1  keypad code accepted this cycle (valid & ready)
- req1_valid  in  1  console has a key code
- req1_key  in  4  console key code
- req1_ready  out  1  console code accepted this cycle
- calc_status  in  2  calculator state: 00 ERRO, 01 PRONTA, 10 OCUPADA, 11 illegal
- calc_cmd  out  4  key code presented to calculator; holds last issued value
- calc_cmd_valid  out  1  one-cycle pulse; top level uses it as the calculator clock enable
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- drop_count  out  CNT_W  keys discarded while in ERRO; saturates at all-ones

## Operation
- Arbitration:
  - Combinational. When FIFO not full, grant = requester at priority pointer if valid, else the other if valid.
  - readyX = grant to X. Push on grant.
  - Pointer moves to the non-granted requester after each grant; reset pointer = 0.
- FIFO full: both readys low. A push is refused while full even if a pop occurs the same cycle.
- Key codes: 0–9 digits, A soma, B subt, C mult, E igual, F backspace. D and any other code pass through unfiltered in PRONTA.
- FSM states IDLE, ISSUE, SETTLE, BUSY; reset → IDLE.
- IDLE:
  - FIFO non-empty and calc_status = PRONTA → pop head, load calc_cmd, go to ISSUE.
  - FIFO non-empty, calc_status = ERRO, head = F → same as PRONTA.
  - FIFO non-empty, calc_status = ERRO, head ≠ F → pop and discard; drop_count +1 (saturating). Stay in IDLE; one discard per cycle.
  - calc_status = OCUPADA or 11 → no pop, stay.
- ISSUE: calc_cmd_valid = 1 for exactly this cycle → SETTLE.
- SETTLE: no issue; wait one cycle for calc_status to reflect the command. Next cycle, status OCUPADA → BUSY, else → IDLE.
- BUSY: hold while OCUPADA; PRONTA or ERRO → IDLE.
- Reset mid-operation: FIFO emptied, pointer 0, calc_cmd 0, calc_cmd_valid 0, drop_count 0, state IDLE. A pending pulse is never emitted.

## Timing
- All outputs except req0_ready/req1_ready are registered.
- Reset values: calc_cmd 0, calc_cmd_valid 0, fifo_level 0, drop_count 0. readys low during reset.
- Accept at edge N → entry visible at N+1 → IDLE pops at N+1 → calc_cmd_valid high in cycle N+2.
- Minimum spacing between calc_cmd_valid pulses: 3 cycles (ISSUE, SETTLE, IDLE).
- Push and pop in the same cycle (not full): level unchanged, order preserved.
- Discard in ERRO does not block pushes. Level decrements while a push increments, as normal.

## Structure
- Package calc_pkg:
  - estado_t enum (ERRO/PRONTA/OCUPADA), shared with the calculator.
  - Key-code constants KEY_SOMA=A, KEY_SUBT=B, KEY_MULT=C, KEY_IGUAL=E, KEY_BACKS=F.
- Sub-module calc_key_fifo: synchronous FIFO (push, pop, full, empty, level) with DEPTH parameter and the same async reset.
- Arbiter and FSM live in calc_key_sequencer.

## Test plan
- Keypad only, keys 1,2,A,3,E; calc_status held PRONTA → calc_cmd_valid pulses carry 1,2,A,3,E in order, spaced ≥3 cycles, first pulse 2 cycles after first accept.
- Both sources valid every cycle, keypad key 5 and console key 7, FIFO draining → accepts alternate 5,7,5,7… starting with keypad; neither source starves.
- Hold calc_status = OCUPADA, push 5 keys with FIFO_DEPTH=4 → 4 accepted, readys low, fifo_level=4, no pulse. Release to PRONTA → pulses resume.
- Issue C then E; model drives OCUPADA the cycle after the E pulse for 10 cycles → FSM enters BUSY, no pulse until PRONTA returns.
- calc_status = ERRO, queue 3,A,F,4 → 3 and A dropped, drop_count=2, F issued. Model returns PRONTA → 4 issued.
- Assert reset during SETTLE with 3 entries queued → fifo_level 0, calc_cmd 0, no pulse after release until new keys arrive.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg
// Types and constants shared between the key sequencer and the calculator
// datapath: calculator status encoding, sequencer FSM states, key codes, and
// the helpers that decide which queued key may go to the calculator.
package calc_pkg;

  // Calculator status as reported on calc_status (2'b11 is illegal).
  typedef enum logic [1:0] {
    ERRO    = 2'b00,
    PRONTA  = 2'b01,
    OCUPADA = 2'b10
  } estado_t;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    SETTLE = 2'b10,
    BUSY   = 2'b11
  } seq_state_t;

  localparam logic [3:0] KEY_SOMA  = 4'hA;
  localparam logic [3:0] KEY_SUBT  = 4'hB;
  localparam logic [3:0] KEY_MULT  = 4'hC;
  localparam logic [3:0] KEY_IGUAL = 4'hE;
  localparam logic [3:0] KEY_BACKS = 4'hF;

  // A key may be issued when the calculator is ready, or when it is in
  // error and the key is backspace (the only way out of ERRO).
  function automatic logic key_issuable(input logic [1:0] status,
                                        input logic [3:0] key);
    return (status == PRONTA) || ((status == ERRO) && (key == KEY_BACKS));
  endfunction

  // In ERRO every key other than backspace is thrown away.
  function automatic logic key_discard(input logic [1:0] status,
                                       input logic [3:0] key);
    return (status == ERRO) && (key != KEY_BACKS);
  endfunction

endpackage

// File: rtl/calc_key_fifo.sv
// calc_key_fifo
// Synchronous FIFO holding accepted key codes.
// Ports:
//   clock, reset      system clock, asynchronous active-low reset
//   push, din         write request and data (ignored while full)
//   pop               read request (ignored while empty)
//   dout              head entry, valid whenever empty is low
//   full, empty       occupancy flags
//   level             number of entries held
module calc_key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (level_r == (AW+1)'(DEPTH));
  assign empty     = (level_r == (AW+1)'(0));
  assign level     = level_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer
// Merges key codes from the keypad (requester 0) and the serial console
// (requester 1) round-robin into a small FIFO, then feeds them one at a time
// to the calculator, honouring its status.
// Ports:
//   clock, reset            system clock, asynchronous active-low reset
//   req0_valid/key/ready    keypad handshake (ready = accepted this cycle)
//   req1_valid/key/ready    console handshake
//   calc_status             calculator state (ERRO/PRONTA/OCUPADA/illegal)
//   calc_cmd                key presented to the calculator, holds last issue
//   calc_cmd_valid          one-cycle issue pulse (calculator clock enable)
//   fifo_level              entries queued
//   drop_count              keys discarded in ERRO, saturating
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req0_valid,
  input  logic [3:0]                  req0_key,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [3:0]                  req1_key,
  output logic                        req1_ready,
  input  logic [1:0]                  calc_status,
  output logic [3:0]                  calc_cmd,
  output logic                        calc_cmd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            drop_count
);

  logic             ptr_r;         // requester with priority next
  logic             grant0_s;
  logic             grant1_s;
  logic             push_s;
  logic [3:0]       push_key_s;
  logic             pop_s;
  logic             take_s;        // head goes to the calculator
  logic             drop_s;        // head is thrown away (ERRO)
  logic [3:0]       head_s;
  logic             full_s;
  logic             empty_s;
  seq_state_t       state_r;
  logic [3:0]       calc_cmd_r;
  logic             calc_cmd_valid_r;
  logic [CNT_W-1:0] drop_count_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Round-robin grant; nothing is granted while the FIFO is full, even if a pop is under way.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!full_s) begin
      if (ptr_r == 1'b0) begin
        if (req0_valid) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = req1_valid;
        end
      end else begin
        if (req1_valid) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = req0_valid;
        end
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Readys are forced low while reset is asserted.
  assign req0_ready = grant0_s & reset;
  assign req1_ready = grant1_s & reset;
  assign push_s     = grant0_s | grant1_s;
  assign push_key_s = grant0_s ? req0_key : req1_key;

  // Priority pointer moves to whichever requester lost the last grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r <= 1'b0;
    end else if (grant0_s) begin
      ptr_r <= 1'b1;
    end else if (grant1_s) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  calc_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (4)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .din   (push_key_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  // Head-of-queue decision, only acted on in IDLE; OCUPADA and 2'b11 leave the queue alone.
  always_comb begin
    take_s = 1'b0;
    drop_s = 1'b0;
    if ((state_r == IDLE) && !empty_s) begin
      take_s = key_issuable(calc_status, head_s);
      drop_s = key_discard(calc_status, head_s);
    end else begin
      take_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  assign pop_s = take_s | drop_s;

  // Issue FSM with registered command, issue pulse and drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r          <= IDLE;
      calc_cmd_r       <= 4'h0;
      calc_cmd_valid_r <= 1'b0;
      drop_count_r     <= {CNT_W{1'b0}};
    end else begin
      calc_cmd_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (take_s) begin
            calc_cmd_r       <= head_s;
            calc_cmd_valid_r <= 1'b1;
            state_r          <= ISSUE;
          end else if (drop_s) begin
            drop_count_r <= sat_inc(drop_count_r);
          end
        end
        ISSUE: begin
          state_r <= SETTLE;
        end
        // The calculator needs one cycle before its status reflects the command.
        SETTLE: begin
          state_r <= (calc_status == OCUPADA) ? BUSY : IDLE;
        end
        BUSY: begin
          if ((calc_status == PRONTA) || (calc_status == ERRO)) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign calc_cmd       = calc_cmd_r;
  assign calc_cmd_valid = calc_cmd_valid_r;
  assign drop_count     = drop_count_r;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench for calc_key_sequencer: tests push expected issued keys
// into a queue, a negedge monitor pops and compares on every issue pulse.
module tb_calc_key_sequencer;
  import calc_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0;
  logic [3:0]  req0_key = 4'h0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [3:0]  req1_key = 4'h0;
  logic        req1_ready;
  logic [1:0]  calc_status = 2'b01;
  logic [3:0]  calc_cmd;
  logic        calc_cmd_valid;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;

  calc_key_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_key       (req0_key),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_key       (req1_key),
    .req1_ready     (req1_ready),
    .calc_status    (calc_status),
    .calc_cmd       (calc_cmd),
    .calc_cmd_valid (calc_cmd_valid),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  logic [3:0] sb_q[$];
  logic [3:0] exp_k;
  int         pulse_count = 0;
  int         last_pulse_cyc = -100;
  bit         capture_first = 1'b0;
  int         first_pulse_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every issue pulse must match the scoreboard head and be spaced >= 3 cycles.
  always @(negedge clock) begin
    if (!reset) begin
      last_pulse_cyc = -100;
    end else if (calc_cmd_valid) begin
      pulse_count++;
      if (capture_first) begin
        first_pulse_cyc = cyc;
        capture_first = 1'b0;
      end
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got cmd %0h expected no pulse", calc_cmd);
      end else begin
        exp_k = sb_q.pop_front();
        if (calc_cmd !== exp_k) begin
          bad++;
          $display("FAIL issued_key: got %0h expected %0h", calc_cmd, exp_k);
        end
      end
      total++;
      if (cyc - last_pulse_cyc < 3) begin
        bad++;
        $display("FAIL pulse_spacing: got %0d cycles expected >= 3", cyc - last_pulse_cyc);
      end
      last_pulse_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Offer one key from a source until accepted; reports negedges waited and the accept cycle.
  task automatic send(input bit src, input logic [3:0] k, output int waits, output int acc_cyc);
    if (src == 1'b0) begin
      req0_valid = 1'b1;
      req0_key   = k;
    end else begin
      req1_valid = 1'b1;
      req1_key   = k;
    end
    waits = 0;
    acc_cyc = -1;
    while (acc_cyc < 0 && waits < 60) begin
      @(negedge clock);
      waits++;
      if ((src == 1'b0 && req0_ready) || (src == 1'b1 && req1_ready)) acc_cyc = cyc;
    end
    check("accept_key", (acc_cyc >= 0), 1);
    @(posedge clock);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    check("drain", sb_q.size(), 0);
    tick(4);
  endtask

  task automatic wait_pulse(input logic [3:0] k, output bit seen);
    int n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clock);
      n++;
      if (calc_cmd_valid && calc_cmd == k) seen = 1'b1;
    end
  endtask

  initial begin
    int w, ac, first_acc, grants, n, pc, acc;
    bit exp_src, seen;
    logic [3:0] keys1 [5];
    keys1[0] = 4'h1; keys1[1] = 4'h2; keys1[2] = KEY_SOMA; keys1[3] = 4'h3; keys1[4] = KEY_IGUAL;

    // Reset state, with a keypad request pending that must not be acknowledged.
    req0_valid = 1'b1;
    req0_key   = 4'h5;
    repeat (2) @(negedge clock);
    check("rst_calc_cmd", calc_cmd, 4'h0);
    check("rst_calc_cmd_valid", calc_cmd_valid, 1'b0);
    check("rst_fifo_level", fifo_level, 3'd0);
    check("rst_drop_count", drop_count, 8'd0);
    check("rst_req0_ready", req0_ready, 1'b0);
    req0_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick(2);

    // Both sources always valid: grants alternate keypad/console, FIFO fills.
    for (int i = 0; i < 8; i++) sb_q.push_back((i % 2 == 0) ? 4'h5 : 4'h7);
    req0_valid = 1'b1; req0_key = 4'h5;
    req1_valid = 1'b1; req1_key = 4'h7;
    grants = 0; n = 0; exp_src = 1'b0;
    while (grants < 8 && n < 200) begin
      @(negedge clock);
      n++;
      if (req0_ready || req1_ready) begin
        check("arb_order", {req0_ready, req1_ready}, exp_src ? 2'b01 : 2'b10);
        exp_src = ~exp_src;
        grants++;
        if (grants == 8) begin
          @(posedge clock);
          #1;
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end else begin
        check("arb_stall_only_when_full", fifo_level, 3'd4);
      end
    end
    check("arb_grants", grants, 8);
    drain();

    // Keypad only, PRONTA: keys issued in order, first pulse 2 cycles after accept.
    capture_first = 1'b1;
    first_acc = 0;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(keys1[i]);
      send(1'b0, keys1[i], w, ac);
      if (i == 0) first_acc = ac;
    end
    drain();
    check("first_pulse_latency", first_pulse_cyc - first_acc, 2);

    // OCUPADA: 4 keys fill the FIFO, 5th refused, no issue; refused even on the popping cycle.
    calc_status = OCUPADA;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(4'(6 + i));
      send(1'b0, 4'(6 + i), w, ac);
    end
    req0_valid = 1'b1;
    req0_key   = 4'h0;
    pc = pulse_count;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("full_ready_low", req0_ready, 1'b0);
      check("full_level", fifo_level, 3'd4);
    end
    @(posedge clock);
    #1;
    check("ocupada_no_pulse", pulse_count, pc);
    calc_status = PRONTA;
    @(negedge clock);
    check("full_pop_cycle_ready_low", req0_ready, 1'b0);
    @(posedge clock);
    #1;
    sb_q.push_back(4'h0);
    send(1'b0, 4'h0, w, ac);
    drain();

    // C then E; calculator busy for 10 cycles after E: nothing issued meanwhile.
    sb_q.push_back(KEY_MULT);
    sb_q.push_back(KEY_IGUAL);
    send(1'b0, KEY_MULT, w, ac);
    send(1'b0, KEY_IGUAL, w, ac);
    wait_pulse(KEY_IGUAL, seen);
    check("e_pulse_seen", seen, 1'b1);
    @(posedge clock);
    #1;
    calc_status = OCUPADA;
    pc = pulse_count;
    sb_q.push_back(4'h2);
    send(1'b0, 4'h2, w, ac);
    tick(9);
    check("busy_no_pulse", pulse_count, pc);
    check("busy_level", fifo_level, 3'd1);
    calc_status = PRONTA;
    drain();

    // ERRO: 3 and A dropped without stalling pushes, F issued, then 4 after PRONTA.
    calc_status = ERRO;
    tick(1);
    check("drop_before", drop_count, 8'd0);
    sb_q.push_back(KEY_BACKS);
    sb_q.push_back(4'h4);
    send(1'b0, 4'h3, w, ac);
    check("erro_push_3", w, 1);
    send(1'b0, KEY_SOMA, w, ac);
    check("erro_push_A", w, 1);
    send(1'b0, KEY_BACKS, w, ac);
    check("erro_push_F", w, 1);
    send(1'b0, 4'h4, w, ac);
    check("erro_push_4", w, 1);
    wait_pulse(KEY_BACKS, seen);
    check("f_pulse_seen", seen, 1'b1);
    @(posedge clock);
    #1;
    calc_status = PRONTA;
    drain();
    check("drop_after_erro", drop_count, 8'd2);

    // Drop counter saturation: 258 more discards on top of 2.
    calc_status = ERRO;
    tick(1);
    req0_valid = 1'b1;
    req0_key   = 4'h1;
    acc = 0; n = 0;
    while (acc < 258 && n < 400) begin
      @(negedge clock);
      n++;
      if (req0_ready) begin
        acc++;
        if (acc == 258) begin
          @(posedge clock);
          #1;
          req0_valid = 1'b0;
        end
      end
    end
    check("sat_accepts", acc, 258);
    tick(3);
    check("drop_saturated", drop_count, 8'hFF);
    check("sat_level", fifo_level, 3'd0);
    calc_status = PRONTA;
    tick(2);

    // Reset during SETTLE with 3 keys still queued.
    calc_status = OCUPADA;
    tick(1);
    for (int i = 0; i < 4; i++) send(1'b0, 4'(1 + i), w, ac);
    check("pre_rst_level", fifo_level, 3'd4);
    sb_q.push_back(4'h1);
    calc_status = PRONTA;
    wait_pulse(4'h1, seen);
    check("pre_rst_pulse_seen", seen, 1'b1);
    @(posedge clock);
    #1;
    check("settle_level", fifo_level, 3'd3);
    reset = 1'b0;
    #1;
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_calc_cmd", calc_cmd, 4'h0);
    check("midrst_valid", calc_cmd_valid, 1'b0);
    check("midrst_drop", drop_count, 8'd0);
    tick(2);
    reset = 1'b1;
    tick(10);
    check("post_rst_level", fifo_level, 3'd0);
    check("post_rst_cmd", calc_cmd, 4'h0);
    sb_q.push_back(4'h9);
    send(1'b1, 4'h9, w, ac);
    drain();
    check("final_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
